misr_signature_unit: RTL and testbench
======================================

MISR_SIGNATURE_UNIT -- requirements
Module: misr_signature_unit

Interface
REQ-001 Parameter WIDTH, default 32, signature register width (2..64).
REQ-002 Parameter POLY, default 32'h0001_0811, feedback taps; bit i set = sig[WIDTH-1] XORed into bit i.
REQ-003 Parameter CNT_W, default 16, width of the compaction cycle counter.
REQ-004 Port CK  in  1  single clock; all state updates on rising edge.
REQ-005 Port RESET  in  1  reset; synchronous and active-high.
REQ-006 Port start  in  1  begin compaction; sampled in IDLE only.
REQ-007 Port abort  in  1  return to IDLE from any state.
REQ-008 Port seed  in  WIDTH  initial signature loaded on start.
REQ-009 Port din  in  WIDTH  parallel response word to compact.
REQ-010 Port din_valid  in  1  din is valid this cycle.
REQ-011 Port cnt_target  in  CNT_W  number of valid words to compact; sampled on start.
REQ-012 Port expected  in  WIDTH  golden signature; sampled on entry to DONE.
REQ-013 Port busy  out  1  high in COMPRESS.
REQ-014 Port sig  out  WIDTH  current signature register.
REQ-015 Port sig_valid  out  1  final signature available (DONE).
REQ-016 Port sig_ready  in  1  consumer accepts signature.
REQ-017 Port pass  out  1  registered (sig == expected); meaningful while sig_valid.
REQ-018 Port scan_en  in  1  serial shift enable, effective in IDLE only.
REQ-019 Port scan_in  in  1  serial input into sig[0].
REQ-020 Port scan_out  out  1  equals sig[WIDTH-1] combinationally.

Function
REQ-021 States: IDLE, COMPRESS, DONE; encoding fixed in package.
REQ-022 IDLE, start=1: sig<=seed, count<=0, target<=cnt_target, next COMPRESS.
REQ-023 IDLE, start=1 and scan_en=1 together: start wins, no shift.
REQ-024 IDLE, scan_en=1, start=0: sig<={sig[WIDTH-2:0],scan_in}; one bit per cycle, MSB out first.
REQ-025 COMPRESS, din_valid=1: sig_next[0]=sig[W-1]^din[0]; sig_next[i]=sig[i-1]^(POLY[i]&sig[W-1])^din[i], i>=1; count<=count+1.
REQ-026 COMPRESS, din_valid=0: sig and count hold.
REQ-027 COMPRESS -> DONE on the cycle after the word making count==target is accepted; no further words taken.
REQ-028 target=0: COMPRESS exits to DONE on first cycle with sig=seed, no words consumed.
REQ-029 start, scan_en ignored outside IDLE.
REQ-030 DONE: sig_valid=1, sig stable, pass=(sig==expected) registered on entry.
REQ-031 DONE, sig_valid&&sig_ready: next IDLE, sig retained, sig_valid and pass drop next cycle.
REQ-032 sig_valid held until accepted; no timeout.
REQ-033 abort=1 in any state: next IDLE, sig retained, sig_valid=0, pass=0; abort beats start and handshake.
REQ-034 count wraps never: target<=2^CNT_W-1, comparison exact.

Reset
REQ-035 RESET=1 at CK edge: state IDLE, sig=0, count=0, target=0, busy=0, sig_valid=0, pass=0; hence scan_out=0.
REQ-036 RESET overrides abort, start, scan_en, din_valid; reset mid-COMPRESS discards partial signature.

Structure
REQ-037 Package misr_pkg holds state enum and default POLY constant 32'h0001_0811.
REQ-038 One sub-module misr_step: combinational next-signature function (sig, din, POLY -> sig_next), instanced once.
REQ-039 Control FSM, counter, compare and scan path reside in misr_signature_unit.

Verification (WIDTH=32, POLY default)
REQ-040 RESET=1 two cycles, then idle -> sig=0, busy=0, sig_valid=0, pass=0, scan_out=0.
REQ-041 seed=0, cnt_target=1, din=32'h0000_0001 one valid cycle, expected=1 -> sig=32'h0000_0001, sig_valid next cycle, pass=1.
REQ-042 seed=32'h8000_0000, cnt_target=1, din=0 -> sig=32'h0001_0811; expected=0 gives pass=0.
REQ-043 cnt_target=3, din_valid pattern 1,0,1,0,1 -> busy 5 cycles, sig_valid cycle 6; sig_ready=0 for 4 cycles keeps sig stable.
REQ-044 After REQ-042 handshake, scan_en=1 32 cycles, scan_in=0 -> scan_out serial 0x00010811 MSB first, then sig=0.
REQ-045 abort during COMPRESS after 2 of 8 words -> IDLE next cycle, busy=0, sig_valid never asserts; start+scan_en same cycle -> seed loaded, no shift.

Source files
------------

// File: rtl/misr_pkg.sv
// MISR shared definitions: control states and the default feedback polynomial.
package misr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMPRESS = 2'd1,
    ST_DONE     = 2'd2
  } misr_state_e;

  localparam logic [31:0] MISR_POLY = 32'h0001_0811;

endpackage

// File: rtl/misr_step.sv
// One parallel MISR compaction step.
// Maps the current signature and the response word to the next signature.
module misr_step #(
  parameter int              WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY = '1
) (
  input  logic [WIDTH-1:0] sig_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] sig_next_o
);

  logic fb;

  assign fb = sig_i[WIDTH-1];

  // Bit 0 always takes the feedback; POLY[0] plays no part.
  always_comb begin
    sig_next_o[0] = fb ^ din_i[0];
    for (int i = 1; i < WIDTH; i++) begin
      sig_next_o[i] = sig_i[i-1]
                    ^ (POLY[i] & fb)
                    ^ din_i[i];
    end
  end

endmodule

// File: rtl/misr_signature_unit.sv
// MISR signature unit: control FSM, word counter, golden compare and scan path.
// The signature step itself is done in misr_step.
module misr_signature_unit
  import misr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_POLY),
  parameter int               CNT_W = 16
) (
  input  logic             CK,
  input  logic             RESET,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic [CNT_W-1:0] cnt_target,
  input  logic [WIDTH-1:0] expected,
  output logic             busy,
  output logic [WIDTH-1:0] sig,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic             pass,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out
);

  misr_state_e      state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic             pass_q, pass_d;
  logic [WIDTH-1:0] step;

  misr_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .sig_i      (sig_q),
    .din_i      (din),
    .sig_next_o (step)
  );

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    pass_d  = pass_q;
    if (abort) begin
      state_d = ST_IDLE;
      pass_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            sig_d   = seed;
            cnt_d   = '0;
            tgt_d   = cnt_target;
            state_d = ST_COMPRESS;
          end else if (scan_en) begin
            sig_d = {sig_q[WIDTH-2:0], scan_in};
          end
        end
        ST_COMPRESS: begin
          // A zero target leaves with the seed untouched.
          if (cnt_q == tgt_q) begin
            state_d = ST_DONE;
            pass_d  = (sig_q == expected);
          end else if (din_valid) begin
            sig_d = step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == tgt_q) begin
              state_d = ST_DONE;
              pass_d  = (step == expected);
            end
          end
        end
        ST_DONE: begin
          if (sig_ready) begin
            state_d = ST_IDLE;
            pass_d  = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      sig_q   <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = (state_q == ST_COMPRESS);
  assign sig_valid = (state_q == ST_DONE);
  assign sig       = sig_q;
  assign pass      = pass_q;
  assign scan_out  = sig_q[WIDTH-1];

endmodule

// File: tb/tb_misr_signature_unit.sv
// Directed bench for misr_signature_unit with a behavioural reference model.
module tb_misr_signature_unit;

  localparam int          W    = 32;
  localparam int          CW   = 16;
  localparam logic [31:0] PLY  = 32'h0001_0811;

  logic          CK = 1'b0;
  logic          RESET;
  logic          start;
  logic          abort;
  logic [W-1:0]  seed;
  logic [W-1:0]  din;
  logic          din_valid;
  logic [CW-1:0] cnt_target;
  logic [W-1:0]  expected;
  logic          busy;
  logic [W-1:0]  sig;
  logic          sig_valid;
  logic          sig_ready;
  logic          pass;
  logic          scan_en;
  logic          scan_in;
  logic          scan_out;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  misr_signature_unit #(
    .WIDTH (W),
    .POLY  (PLY),
    .CNT_W (CW)
  ) dut (
    .CK         (CK),
    .RESET      (RESET),
    .start      (start),
    .abort      (abort),
    .seed       (seed),
    .din        (din),
    .din_valid  (din_valid),
    .cnt_target (cnt_target),
    .expected   (expected),
    .busy       (busy),
    .sig        (sig),
    .sig_valid  (sig_valid),
    .sig_ready  (sig_ready),
    .pass       (pass),
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .scan_out   (scan_out)
  );

  always #5 CK = ~CK;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp_v);
    end
  endtask

  // Reference: polynomial arithmetic, counting remaining words down.
  function automatic logic [W-1:0] mstep(
    input logic [W-1:0] s, input logic [W-1:0] d);
    logic [W-1:0] fbv;
    fbv = s[W-1] ? (PLY | 32'h1) : '0;
    return (s << 1) ^ d ^ fbv;
  endfunction

  int           m_mode = 0;
  logic [W-1:0] m_sig  = '0;
  int           m_left = 0;
  bit           m_pass = 1'b0;

  always @(posedge CK) begin
    if (RESET) begin
      m_mode = 0;
      m_sig  = '0;
      m_left = 0;
      m_pass = 1'b0;
    end else if (abort) begin
      m_mode = 0;
      m_pass = 1'b0;
    end else if (m_mode == 0) begin
      if (start) begin
        m_sig  = seed;
        m_left = int'(cnt_target);
        m_mode = 1;
      end else if (scan_en) begin
        m_sig = {m_sig[W-2:0], scan_in};
      end
    end else if (m_mode == 1) begin
      if (m_left == 0) begin
        m_mode = 2;
        m_pass = (m_sig == expected);
      end else if (din_valid) begin
        m_sig  = mstep(m_sig, din);
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_mode = 2;
          m_pass = (m_sig == expected);
        end
      end
    end else begin
      if (sig_ready) begin
        m_mode = 0;
        m_pass = 1'b0;
      end
    end
  end

  always @(negedge CK) begin
    if (mon_en) begin
      chk("mon_busy", 64'(busy), 64'(m_mode == 1));
      chk("mon_valid", 64'(sig_valid), 64'(m_mode == 2));
      chk("mon_sig", 64'(sig), 64'(m_sig));
      chk("mon_scan", 64'(scan_out), 64'(m_sig[W-1]));
      if (m_mode == 2)
        chk("mon_pass", 64'(pass), 64'(m_pass));
      else
        chk("mon_nopass", 64'(pass), 64'(0));
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic start_run(input logic [W-1:0] s,
                           input logic [CW-1:0] t);
    seed       = s;
    cnt_target = t;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic handshake();
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;
  endtask

  int           nbusy;
  logic [W-1:0] word;
  logic [W-1:0] held;

  initial begin
    RESET      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    seed       = '0;
    din        = '0;
    din_valid  = 1'b0;
    cnt_target = '0;
    expected   = '0;
    sig_ready  = 1'b0;
    scan_en    = 1'b0;
    scan_in    = 1'b0;

    // Reset behaviour, with other controls asserted
    tick();
    mon_en = 1'b1;
    start  = 1'b1;
    abort  = 1'b1;
    tick();
    start  = 1'b0;
    abort  = 1'b0;
    RESET  = 1'b0;
    tick();
    chk("rst_sig", 64'(sig), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_valid", 64'(sig_valid), 64'(0));
    chk("rst_pass", 64'(pass), 64'(0));
    chk("rst_scan", 64'(scan_out), 64'(0));

    // Single word into a zero seed
    expected = 32'h0000_0001;
    start_run('0, 16'd1);
    din       = 32'h0000_0001;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("w1_sig", 64'(sig), 64'h1);
    chk("w1_valid", 64'(sig_valid), 64'(1));
    chk("w1_pass", 64'(pass), 64'(1));
    handshake();
    chk("w1_drop", 64'(sig_valid), 64'(0));
    chk("w1_pdrop", 64'(pass), 64'(0));
    chk("w1_keep", 64'(sig), 64'h1);

    // MSB feedback injects the polynomial
    expected = '0;
    start_run(32'h8000_0000, 16'd1);
    din       = '0;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("fb_sig", 64'(sig), 64'h0001_0811);
    chk("fb_model", 64'(m_sig), 64'h0001_0811);
    chk("fb_pass", 64'(pass), 64'(0));
    handshake();

    // Serial unload, MSB first
    scan_en = 1'b1;
    scan_in = 1'b0;
    word    = '0;
    for (int i = 0; i < W; i++) begin
      word = {word[W-2:0], scan_out};
      tick();
    end
    scan_en = 1'b0;
    chk("scan_word", 64'(word), 64'h0001_0811);
    chk("scan_sig", 64'(sig), 64'(0));

    // Gapped valid, scan ignored while compressing
    expected = 32'h0000_0007;
    start_run('0, 16'd3);
    nbusy = 0;
    din   = 32'h0000_0001;
    for (int i = 0; i < 5; i++) begin
      din_valid = (i % 2 == 0);
      scan_en   = (i == 1);
      scan_in   = 1'b1;
      if (busy) nbusy++;
      tick();
    end
    din_valid = 1'b0;
    scan_en   = 1'b0;
    scan_in   = 1'b0;
    chk("gap_busy", 64'(nbusy), 64'(5));
    chk("gap_valid", 64'(sig_valid), 64'(1));
    chk("gap_sig", 64'(sig), 64'h7);
    chk("gap_pass", 64'(pass), 64'(1));
    held = sig;
    for (int i = 0; i < 4; i++) tick();
    chk("gap_hold", 64'(sig), 64'(held));
    chk("gap_still", 64'(sig_valid), 64'(1));
    handshake();

    // Abort after two of eight words
    start_run(32'h0000_0005, 16'd8);
    din_valid = 1'b1;
    din       = 32'h0000_0010;
    tick();
    din       = 32'h0000_0020;
    tick();
    abort = 1'b1;
    tick();
    abort     = 1'b0;
    din_valid = 1'b0;
    chk("ab_busy", 64'(busy), 64'(0));
    chk("ab_valid", 64'(sig_valid), 64'(0));
    chk("ab_sig", 64'(sig), 64'h14);
    for (int i = 0; i < 3; i++) tick();

    // Start beats scan; zero target returns the seed
    expected = 32'hA5A5_0F0F;
    scan_en  = 1'b1;
    scan_in  = 1'b1;
    start_run(32'hA5A5_0F0F, 16'd0);
    scan_en  = 1'b0;
    chk("ss_sig", 64'(sig), 64'hA5A5_0F0F);
    chk("ss_busy", 64'(busy), 64'(1));
    tick();
    chk("z_valid", 64'(sig_valid), 64'(1));
    chk("z_pass", 64'(pass), 64'(1));
    chk("z_sig", 64'(sig), 64'hA5A5_0F0F);

    // Abort beats the handshake in DONE
    abort     = 1'b1;
    sig_ready = 1'b1;
    tick();
    abort     = 1'b0;
    sig_ready = 1'b0;
    chk("abd_valid", 64'(sig_valid), 64'(0));
    chk("abd_pass", 64'(pass), 64'(0));

    // Reset mid-compress discards the partial signature
    start_run(32'h1234_5678, 16'd4);
    din_valid = 1'b1;
    din       = 32'hDEAD_BEEF;
    tick();
    RESET = 1'b1;
    tick();
    RESET     = 1'b0;
    din_valid = 1'b0;
    chk("rc_sig", 64'(sig), 64'(0));
    chk("rc_busy", 64'(busy), 64'(0));
    tick();

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
